// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR stream sequencer.
// Holds the stream/FIR widths, the FSM state type, the saturation bounds and
// the round-half-up / saturate helper applied to every FIR result.
package fir_ctrl_pkg;

    localparam int DW         = 16;   // sample width
    localparam int YW         = 31;   // FIR result width
    localparam int TAPS       = 32;   // zeros issued per flush
    localparam int FIR_LAT    = 4;    // fir_en -> fir_valid latency
    localparam int SHIFT      = 15;   // coefficient Q format
    localparam int FIFO_DEPTH = 8;    // output buffer entries

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int ZW = $clog2(TAPS);

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [YW:0]   RND_ADD = {{YW{1'b0}}, 1'b1} << (SHIFT - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic          sat;
        logic [DW-1:0] val;
    } rs_t;

    // Round half up, arithmetic shift, then clamp into the signed DW range.
    // The sum is one bit wider than the FIR result so the rounding add cannot wrap.
    function automatic rs_t round_sat(input logic [YW-1:0] y);
        rs_t                r;
        logic signed [YW:0] sum_s;
        logic signed [YW:0] shf_s;
        sum_s = {y[YW-1], y} + RND_ADD;
        shf_s = sum_s >>> SHIFT;
        // Result fits when every bit above the DW sign bit equals the sign bit.
        if (shf_s[YW:DW-1] == {(YW-DW+2){shf_s[YW]}}) begin
            r.sat = 1'b0;
            r.val = shf_s[DW-1:0];
        end else begin
            r.sat = 1'b1;
            r.val = shf_s[YW] ? SAT_MIN : SAT_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: synchronous first-word-fall-through FIFO, FIFO_DEPTH x DW.
// Ports: clk, rstn (async active-low); wr_en/wr_data write side;
//        rd_en pops the head; rd_data is the head word; empty; count = occupancy.
module fir_out_fifo
    import fir_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [DW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_fire_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_fire_s = rd_en && (count_q != {CW{1'b0}});
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_fire_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {{(CW-1){1'b0}}, wr_en} - {{(CW-1){1'b0}}, rd_fire_s};
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == {CW{1'b0}});
    assign count   = count_q;

    fir_out_fifo_chk u_chk (
        .clk   (clk),
        .rstn  (rstn),
        .wr_en (wr_en),
        .full  (count_q == CW'(FIFO_DEPTH))
    );

endmodule

// fir_out_fifo_chk: the credit scheme must never let a write hit a full FIFO.
module fir_out_fifo_chk (
    input logic clk,
    input logic rstn,
    input logic wr_en,
    input logic full
);

    property p_no_overflow;
        @(posedge clk) disable iff (!rstn) !(wr_en && full);
    endproperty

    a_no_overflow: assert property (p_no_overflow);

endmodule

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: sequencer in front of a shared FIR.
// Accepts samples on s_valid/s_ready, issues them as single-cycle fir_en pulses,
// tags each in-flight operation, rounds/saturates the FIR result and buffers it
// for a back-pressurable consumer on m_valid/m_ready. flush feeds TAPS zeros
// through the FIR (results dropped). busy = FLUSH or DRAIN; sat_flag is sticky.
module fir_stream_ctrl
    import fir_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    input  logic          flush,
    output logic          busy,
    output logic          sat_flag,
    output logic          fir_en,
    output logic [DW-1:0] fir_xin,
    input  logic          fir_valid,
    input  logic [YW-1:0] fir_yout
);

    state_e             state_q, state_d;
    logic [ZW-1:0]      zero_cnt_q, zero_cnt_d;
    logic               fir_en_q, fir_en_d;
    logic [DW-1:0]      fir_xin_q, fir_xin_d;
    logic               keep_q, keep_d;
    logic [FIR_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [FIR_LAT-1:0] tag_keep_q, tag_keep_d;
    logic               res_vld_q, res_vld_d;
    logic [DW-1:0]      res_data_q, res_data_d;
    logic               sat_q, sat_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic               busy_q, busy_d;
    logic               ready_en_q;

    logic               hs_s;
    logic               take_s;
    logic               flush_acc_s;
    logic [CW:0]        credit_s;
    logic [CW-1:0]      fifo_cnt_s;
    logic               fifo_empty_s;
    rs_t                rs_s;

    // Credit = buffered results plus kept samples not yet written to the FIFO,
    // so every accepted sample is guaranteed a FIFO slot. ready_en_q keeps
    // s_ready low while reset is held.
    assign credit_s = {1'b0, fifo_cnt_s} + {1'b0, inflight_q};
    assign s_ready  = ready_en_q && (state_q == ST_RUN) && (credit_s < (CW+1)'(FIFO_DEPTH));
    assign hs_s     = s_valid && s_ready;

    // FIR results arriving with an empty tag pipe (e.g. after reset) are ignored.
    assign rs_s   = round_sat(fir_yout);
    assign take_s = fir_valid && tag_vld_q[FIR_LAT-1] && tag_keep_q[FIR_LAT-1];

    // FSM next state, FIR issue, flush sequencing and busy.
    always_comb begin
        state_d     = state_q;
        zero_cnt_d  = zero_cnt_q;
        fir_en_d    = 1'b0;
        fir_xin_d   = {DW{1'b0}};
        keep_d      = 1'b0;
        flush_acc_s = 1'b0;
        if (hs_s) begin
            fir_en_d  = 1'b1;
            fir_xin_d = s_data;
            keep_d    = 1'b1;
        end else begin
            fir_en_d  = 1'b0;
        end
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d     = ST_FLUSH;
                    zero_cnt_d  = {ZW{1'b0}};
                    flush_acc_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                fir_en_d  = 1'b1;
                fir_xin_d = {DW{1'b0}};
                keep_d    = 1'b0;
                if (zero_cnt_q == ZW'(TAPS - 1)) begin
                    state_d    = ST_DRAIN;
                    zero_cnt_d = {ZW{1'b0}};
                end else begin
                    zero_cnt_d = zero_cnt_q + {{(ZW-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                // Last zero may still sit in the issue register before entering the tag pipe.
                if (!fir_en_q && (tag_vld_q == {FIR_LAT{1'b0}}) && !res_vld_q) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        busy_d = (state_d != ST_RUN);
    end

    // Tag pipe, result register, sticky saturation and in-flight accounting.
    always_comb begin
        tag_vld_d  = {tag_vld_q[FIR_LAT-2:0], fir_en_q};
        tag_keep_d = {tag_keep_q[FIR_LAT-2:0], keep_q};
        res_vld_d  = take_s;
        res_data_d = res_data_q;
        sat_d      = sat_q;
        if (take_s) begin
            res_data_d = rs_s.val;
        end else begin
            res_data_d = res_data_q;
        end
        if (flush_acc_s) begin
            sat_d = 1'b0;
        end else if (take_s && rs_s.sat) begin
            sat_d = 1'b1;
        end else begin
            sat_d = sat_q;
        end
        inflight_d = inflight_q + {{(CW-1){1'b0}}, hs_s} - {{(CW-1){1'b0}}, res_vld_q};
    end

    // All control and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_RUN;
            zero_cnt_q <= {ZW{1'b0}};
            fir_en_q   <= 1'b0;
            fir_xin_q  <= {DW{1'b0}};
            keep_q     <= 1'b0;
            tag_vld_q  <= {FIR_LAT{1'b0}};
            tag_keep_q <= {FIR_LAT{1'b0}};
            res_vld_q  <= 1'b0;
            res_data_q <= {DW{1'b0}};
            sat_q      <= 1'b0;
            inflight_q <= {CW{1'b0}};
            busy_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            zero_cnt_q <= zero_cnt_d;
            fir_en_q   <= fir_en_d;
            fir_xin_q  <= fir_xin_d;
            keep_q     <= keep_d;
            tag_vld_q  <= tag_vld_d;
            tag_keep_q <= tag_keep_d;
            res_vld_q  <= res_vld_d;
            res_data_q <= res_data_d;
            sat_q      <= sat_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            ready_en_q <= 1'b1;
        end
    end

    fir_out_fifo u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (res_vld_q),
        .wr_data (res_data_q),
        .rd_en   (m_ready),
        .rd_data (m_data),
        .empty   (fifo_empty_s),
        .count   (fifo_cnt_s)
    );

    assign m_valid  = !fifo_empty_s;
    assign busy     = busy_q;
    assign sat_flag = sat_q;
    assign fir_en   = fir_en_q;
    assign fir_xin  = fir_xin_q;

endmodule
